apb_adder_slave: RTL
====================

# apb_adder_slave

APB3 completer that sits directly downstream of the APB adder master and answers its SETUP/ACCESS transfers on the 8-bit data bus. It holds two operand registers, runs a bit-serial 8-bit add on command, and returns result and status. It generates wait states through `pready_o` and flags illegal accesses on `pslverr_o`.

## Interface
- `BASE_ADDR`, default 32'h00D0_AD00: base of the 5-register window; the register offset is `paddr_i[4:0]`.
- `WAIT_STATES`, default 0, legal range 0..3: extra ACCESS cycles inserted before `pready_o` rises.

- `pclk` in 1: single clock, rising edge.
- `preset` in 1: synchronous, active-high reset.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable; high during the ACCESS phase.
- `pwrite_i` in 1: 1 = write, 0 = read.
- `paddr_i` in 32: byte address.
- `pwdata_i` in 8: write data.
- `prdata_o` out 8: read data.
- `pready_o` out 1: transfer completes on a cycle where it is high.
- `pslverr_o` out 1: error; only meaningful while `pready_o` is high.
- `irq_o` out 1: equals the DONE flag.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - 0x00 OPA, RW.
  - 0x04 OPB, RW.
  - 0x08 CTRL, WO: bit0 = START, bit1 = CLR_DONE; reads return 0.
  - 0x0C RESULT, RO.
  - 0x10 STATUS, RO: bit0 BUSY, bit1 DONE, bit2 CARRY, bits[7:3] = 0.
- Decode:
  - An address outside `BASE_ADDR`..`BASE_ADDR`+0x10, or not 4-byte aligned, completes with `pslverr_o`=1.
  - A write to RESULT or STATUS completes with `pslverr_o`=1.
  - An errored access changes no state.
- START while BUSY=0:
  - Clears DONE and CARRY.
  - Loads shift copies of OPA and OPB.
  - Runs 8 cycles, LSB first: sum bit = a^b^c, carry = majority.
  - After the 8th bit: RESULT = sum, CARRY = carry-out, DONE=1, BUSY=0.
- START while BUSY=1: completes with `pslverr_o`=1; the running add is unaffected.
- Write to OPA or OPB while BUSY=1: completes with `pslverr_o`=1; the register is unchanged.
- START and CLR_DONE in the same write: START wins, so DONE ends 0 and an add begins.
- CLR_DONE alone clears DONE.
- Read of RESULT while BUSY=1: `pready_o` is held low until BUSY falls, then the new RESULT is returned. This stall adds to any `WAIT_STATES`.
- Compute FSM states:
  - C_IDLE: goes to C_RUN on an accepted START.
  - C_RUN: a 3-bit counter runs 0..7; goes to C_IDLE when count = 7.
- Bus FSM states:
  - B_IDLE: goes to B_SETUP on `psel_i` & !`penable_i`.
  - B_SETUP: loads the wait counter with `WAIT_STATES`; goes to B_ACCESS.
  - B_ACCESS: `pready_o` is high when the wait counter = 0 and there is no RESULT stall; returns to B_IDLE on that cycle.
  - A `psel_i`&`penable_i` cycle without a preceding SETUP is ignored and `pready_o` stays 0.

## Timing
- Reset values, applied one edge after `preset` is sampled high:
  - All registers, flags and counters are 0.
  - Both FSMs are in their idle states.
  - `pready_o`=0, `pslverr_o`=0, `prdata_o`=0, `irq_o`=0.
- Reset mid-add or mid-transfer aborts it; no partial RESULT is kept.
- With `WAIT_STATES`=0, `pready_o` is high in the first ACCESS cycle; each unit of `WAIT_STATES` adds one cycle.
- `prdata_o` is valid only while `pready_o`=1 and the access is a read; at all other times it is 0.
- Writes commit at the edge that ends the `pready_o`=1 cycle.
- START accepted at edge T:
  - BUSY=1 from T through T+8.
  - BUSY=0, DONE=1 and RESULT valid from edge T+8 onward.
  - The add takes 8 cycles.
- Operands are snapshotted at START; later changes to OPA or OPB do not affect the running add.
- An add completing in the same cycle as a CLR_DONE write: completion wins, so DONE=1.

## Structure
- Package `apb_adder_pkg` holds:
  - The register offset localparams.
  - The CTRL and STATUS bit indices.
  - The `bus_state_t` {B_IDLE, B_SETUP, B_ACCESS} and `calc_state_t` {C_IDLE, C_RUN} enums.
- Sub-module `serial_adder8`:
  - Inputs: `start`, `a[7:0]`, `b[7:0]`.
  - Outputs: `busy`, a `done` pulse, `sum[7:0]`, `cout`.
  - It owns the shift registers, the carry flop and the bit counter.
- The top level owns the bus FSM, decode, registers and the wait counter.

## Test plan
- OPA=8'h5A, OPB=8'h3C, START, poll STATUS → RESULT=8'h96, STATUS=8'h02, `irq_o`=1 exactly 8 cycles after the START commit.
- OPA=8'hFF, OPB=8'h01, START, then read RESULT immediately → `pready_o` is stalled until done, read returns 8'h00, STATUS=8'h06.
- START, then during BUSY write OPA=8'h11 and a second START → both complete with `pslverr_o`=1; the first sum is unchanged.
- `WAIT_STATES`=3, read OPA → `pready_o` rises in the 4th ACCESS cycle; read from offset 0x14 and write to RESULT → `pslverr_o`=1.
- Assert `preset` at cycle 4 of an add → the next cycle BUSY=0, DONE=0, RESULT=0, `pready_o`=0.
- Write CTRL=8'h03 while DONE=1 → DONE=0, BUSY=1, and a new add completes after 8 cycles.

Source files
------------

// File: rtl/apb_adder_pkg.sv
// apb_adder_pkg: register map, control/status bit positions and FSM state types
package apb_adder_pkg;
   localparam logic [4:0] OFF_OPA    = 5'h00;
   localparam logic [4:0] OFF_OPB    = 5'h04;
   localparam logic [4:0] OFF_CTRL   = 5'h08;
   localparam logic [4:0] OFF_RESULT = 5'h0C;
   localparam logic [4:0] OFF_STATUS = 5'h10;
   localparam int CTRL_START    = 0;
   localparam int CTRL_CLR_DONE = 1;
   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_CARRY = 2;
   typedef enum logic [1:0] {B_IDLE, B_SETUP, B_ACCESS} bus_state_t;
   typedef enum logic {C_IDLE, C_RUN} calc_state_t;
endpackage

// File: rtl/serial_adder8.sv
// serial_adder8: LSB-first bit-serial 8-bit adder, one bit per clock over 8 clocks
module serial_adder8
   import apb_adder_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] sum,
   output logic       cout
);
   calc_state_t state;
   logic [2:0] cnt;
   logic [7:0] sa, sb;
   logic [6:0] acc;
   logic       c, bit_s, bit_c;
   assign bit_s = sa[0] ^ sb[0] ^ c;
   assign bit_c = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
   assign busy  = state == C_RUN;
   // sum/cout are only meaningful in the done cycle, when the last bit is in flight
   assign done  = busy && cnt == 3'd7;
   assign sum   = {bit_s, acc};
   assign cout  = bit_c;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= C_IDLE;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         c     <= 1'b0;
      end else if (state == C_IDLE) begin
         if (start) begin
            state <= C_RUN;
            cnt   <= '0;
            sa    <= a;
            sb    <= b;
            c     <= 1'b0;
         end
      end else begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         c     <= bit_c;
         acc   <= {bit_s, acc[6:1]};
         cnt   <= cnt + 3'd1;
         state <= cnt == 3'd7 ? C_IDLE : C_RUN;
      end
   end
endmodule

// File: rtl/apb_adder_slave.sv
// apb_adder_slave: APB3 completer with operand/result registers around a serial adder
module apb_adder_slave
   import apb_adder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h00D0_AD00,
   parameter int          WAIT_STATES = 0
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] paddr_i,
   input  logic [7:0]  pwdata_i,
   output logic [7:0]  prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        irq_o
);
   bus_state_t  bstate;
   logic [1:0]  wcnt;
   logic [31:0] rel;
   logic [4:0]  off;
   logic [7:0]  opa, opb, result, status, rdata, add_sum;
   logic        carry, done_flag, add_busy, add_done, add_cout;
   logic        hit, stall, err, commit, ctrl_wr, start;
   assign rel     = paddr_i - BASE_ADDR;
   assign off     = rel[4:0];
   assign hit     = rel <= 32'h10 && rel[1:0] == 2'b00;
   assign stall   = hit && !pwrite_i && off == OFF_RESULT && add_busy;
   assign pready_o = bstate != B_IDLE && psel_i && penable_i && wcnt == 2'd0 && !stall;
   assign err     = !hit || (pwrite_i && (off == OFF_RESULT || off == OFF_STATUS)) ||
                    (pwrite_i && add_busy && (off == OFF_OPA || off == OFF_OPB ||
                                              (off == OFF_CTRL && pwdata_i[CTRL_START])));
   assign commit  = pready_o && pwrite_i && !err;
   assign ctrl_wr = commit && off == OFF_CTRL;
   assign start   = ctrl_wr && pwdata_i[CTRL_START];
   always_comb begin
      status             = '0;
      status[STAT_BUSY]  = add_busy;
      status[STAT_DONE]  = done_flag;
      status[STAT_CARRY] = carry;
      rdata = off == OFF_OPA ? opa : off == OFF_OPB ? opb :
              off == OFF_RESULT ? result : off == OFF_STATUS ? status : '0;
   end
   assign prdata_o  = pready_o && !pwrite_i && !err ? rdata : '0;
   assign pslverr_o = pready_o && err;
   assign irq_o     = done_flag;
   serial_adder8 u_add (
      .clk(pclk), .rst(preset), .start(start), .a(opa), .b(opb),
      .busy(add_busy), .done(add_done), .sum(add_sum), .cout(add_cout)
   );
   // wait states are consumed only while not stalled on a busy RESULT read, so the two add up
   always_ff @(posedge pclk) begin
      if (preset) begin
         bstate <= B_IDLE;
         wcnt   <= '0;
      end else if (bstate == B_IDLE || !penable_i) begin
         if (psel_i && !penable_i) begin
            bstate <= B_SETUP;
            wcnt   <= 2'(WAIT_STATES);
         end else
            bstate <= B_IDLE;
      end else if (pready_o || !psel_i)
         bstate <= B_IDLE;
      else begin
         bstate <= B_ACCESS;
         if (wcnt != 2'd0 && !stall) wcnt <= wcnt - 2'd1;
      end
   end
   // completion outranks a same-cycle CLR_DONE; START cannot coincide with completion
   always_ff @(posedge pclk) begin
      if (preset) begin
         opa       <= '0;
         opb       <= '0;
         result    <= '0;
         carry     <= 1'b0;
         done_flag <= 1'b0;
      end else begin
         if (commit && off == OFF_OPA) opa <= pwdata_i;
         if (commit && off == OFF_OPB) opb <= pwdata_i;
         if (add_done) result <= add_sum;
         carry     <= add_done ? add_cout : start ? 1'b0 : carry;
         done_flag <= add_done || (done_flag && !(ctrl_wr && (pwdata_i[CTRL_START] || pwdata_i[CTRL_CLR_DONE])));
      end
   end
endmodule
